// File: rtl/norm_flotante.sv
// Floating-point normalizer: left-justifies a raw product mantissa, rounds to nearest even,
// and saturates the exponent into a compact {sign, exp, man} result with a valid/ready handshake.
module norm_flotante #(
    parameter int NB_MAN_IN    = 16,
    parameter int NB_EXP_IN    = 7,
    parameter int NB_EXPONENTE = 4,
    parameter int NB_MANTISA   = 8
) (
    input  logic                                 clock,
    input  logic                                 i_reset,
    input  logic                                 i_valid,
    output logic                                 o_ready,
    input  logic                                 i_sign,
    input  logic [NB_EXP_IN-1:0]                 i_exp,
    input  logic [NB_MAN_IN-1:0]                 i_man,
    output logic                                 o_valid,
    input  logic                                 i_ready,
    output logic [NB_EXPONENTE+NB_MANTISA:0]     o_result,
    output logic                                 o_ovf,
    output logic                                 o_unf
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] NORM  = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    localparam int NB_EXP_INT  = NB_EXP_IN + 1;
    localparam int NB_EXP_CALC = NB_EXP_IN + 3;
    localparam int NB_RESULT   = 1 + NB_EXPONENTE + NB_MANTISA;

    localparam logic signed [NB_EXP_CALC-1:0] EXP_ONE = NB_EXP_CALC'(1);
    localparam logic signed [NB_EXP_CALC-1:0] EXP_MAX = NB_EXP_CALC'((1 << NB_EXPONENTE) - 1);

    logic [1:0]                  state_r;
    logic [1:0]                  next_state_s;
    logic                        sign_r;
    logic [NB_EXP_INT-1:0]       exp_r;
    logic [NB_MAN_IN-1:0]        man_r;
    logic [NB_RESULT-1:0]        result_r;
    logic                        ovf_r;
    logic                        unf_r;
    logic                        valid_r;
    logic                        ready_r;

    logic [NB_MANTISA-1:0]       mant_s;
    logic                        guard_s;
    logic                        sticky_s;
    logic                        lsb_s;
    logic [NB_MANTISA:0]         mant_inc_s;
    logic [NB_MANTISA-1:0]       mant_fin_s;
    logic signed [NB_EXP_CALC-1:0] exp_calc_s;
    logic [NB_RESULT-1:0]        round_result_s;
    logic                        round_ovf_s;
    logic                        round_unf_s;

    // Next-state decode for the single-operand FSM.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_valid) next_state_s = NORM;
                else         next_state_s = IDLE;
            end
            NORM: begin
                if (man_r == {NB_MAN_IN{1'b0}})  next_state_s = OUT;
                else if (man_r[NB_MAN_IN-1])     next_state_s = ROUND;
                else                             next_state_s = NORM;
            end
            ROUND: next_state_s = OUT;
            OUT: begin
                if (i_ready) next_state_s = IDLE;
                else         next_state_s = OUT;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Round-to-nearest-even on the normalized mantissa, then exponent saturation.
    always_comb begin
        mant_s     = man_r[NB_MAN_IN-1 -: NB_MANTISA];
        guard_s    = man_r[NB_MAN_IN-NB_MANTISA-1];
        sticky_s   = |man_r[NB_MAN_IN-NB_MANTISA-2:0];
        lsb_s      = man_r[NB_MAN_IN-NB_MANTISA];
        mant_inc_s = {1'b0, mant_s} + {{NB_MANTISA{1'b0}}, guard_s & (sticky_s | lsb_s)};
        // A carry out of the mantissa renormalizes to the leading one and bumps the exponent.
        exp_calc_s = {{2{exp_r[NB_EXP_INT-1]}}, exp_r} + EXP_ONE
                   + {{(NB_EXP_CALC-1){1'b0}}, mant_inc_s[NB_MANTISA]};
        if (mant_inc_s[NB_MANTISA]) mant_fin_s = mant_inc_s[NB_MANTISA:1];
        else                        mant_fin_s = mant_inc_s[NB_MANTISA-1:0];

        round_ovf_s    = 1'b0;
        round_unf_s    = 1'b0;
        round_result_s = {NB_RESULT{1'b0}};
        if (exp_calc_s > EXP_MAX) begin
            round_ovf_s    = 1'b1;
            round_result_s = {sign_r, {NB_EXPONENTE{1'b1}}, {NB_MANTISA{1'b1}}};
        end else if (exp_calc_s < EXP_ONE) begin
            round_unf_s    = 1'b1;
            round_result_s = {NB_RESULT{1'b0}};
        end else begin
            round_result_s = {sign_r, exp_calc_s[NB_EXPONENTE-1:0], mant_fin_s};
        end
    end

    // State, datapath and registered handshake/result outputs.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_r  <= IDLE;
            sign_r   <= 1'b0;
            exp_r    <= {NB_EXP_INT{1'b0}};
            man_r    <= {NB_MAN_IN{1'b0}};
            result_r <= {NB_RESULT{1'b0}};
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
            valid_r  <= 1'b0;
            ready_r  <= 1'b1;
        end else begin
            state_r <= next_state_s;
            valid_r <= (next_state_s == OUT);
            ready_r <= (next_state_s == IDLE);
            case (state_r)
                IDLE: begin
                    if (i_valid) begin
                        sign_r <= i_sign;
                        exp_r  <= {i_exp[NB_EXP_IN-1], i_exp};
                        man_r  <= i_man;
                    end else begin
                        man_r  <= man_r;
                    end
                end
                NORM: begin
                    if (man_r == {NB_MAN_IN{1'b0}}) begin
                        result_r <= {NB_RESULT{1'b0}};
                        ovf_r    <= 1'b0;
                        unf_r    <= 1'b0;
                    end else if (!man_r[NB_MAN_IN-1]) begin
                        man_r <= {man_r[NB_MAN_IN-2:0], 1'b0};
                        exp_r <= exp_r - {{(NB_EXP_INT-1){1'b0}}, 1'b1};
                    end else begin
                        man_r <= man_r;
                    end
                end
                ROUND: begin
                    result_r <= round_result_s;
                    ovf_r    <= round_ovf_s;
                    unf_r    <= round_unf_s;
                end
                OUT: begin
                    result_r <= result_r;
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign o_ready  = ready_r;
    assign o_valid  = valid_r;
    assign o_result = result_r;
    assign o_ovf    = ovf_r;
    assign o_unf    = unf_r;

endmodule

// File: doc/norm_flotante.md
NORM_FLOTANTE -- requirements
Module: norm_flotante

Interface
REQ-001 Parameter NB_MAN_IN, default 16, width of raw mantissa product.
REQ-002 Parameter NB_EXP_IN, default 7, width of raw two's-complement exponent.
REQ-003 Parameter NB_EXPONENTE, default 4, width of output biased exponent.
REQ-004 Parameter NB_MANTISA, default 8, width of output mantissa; explicit leading one at its MSB.
REQ-005 Port clock  input  1  rising-edge clock.
REQ-006 Port i_reset  input  1  synchronous, active-high reset.
REQ-007 Port i_valid  input  1  upstream operand valid.
REQ-008 Port o_ready  output  1  block can accept an operand.
REQ-009 Port i_sign  input  1  product sign.
REQ-010 Port i_exp  input  NB_EXP_IN  signed raw exponent, bias 7.
REQ-011 Port i_man  input  NB_MAN_IN  unsigned raw mantissa; value = (-1)^s * i_man/2^14 * 2^(i_exp-7).
REQ-012 Port o_valid  output  1  result valid.
REQ-013 Port i_ready  input  1  downstream accepts result.
REQ-014 Port o_result  output  1+NB_EXPONENTE+NB_MANTISA  {sign, exp, man}; value = (-1)^s * man/2^7 * 2^(exp-7).
REQ-015 Port o_ovf  output  1  result saturated, valid with o_valid.
REQ-016 Port o_unf  output  1  result flushed to zero, valid with o_valid.

Function
REQ-017 FSM states: IDLE, NORM, ROUND, OUT; one operand in flight.
REQ-018 IDLE: o_ready=1, o_valid=0; on i_valid=1, capture i_sign, i_exp sign-extended to NB_EXP_IN+1 bits, and i_man; go to NORM.
REQ-019 NORM, one decision per cycle: man==0 -> OUT with zero result; man[MSB]=1 -> ROUND; otherwise man <<= 1, exp -= 1, stay in NORM.
REQ-020 NORM exits after at most NB_MAN_IN-1 shifts.
REQ-021 ROUND: exp_pre = exp+1; mant = man[15:8]; guard = man[7]; sticky = |man[6:0]; lsb = man[8].
REQ-022 ROUND: round to nearest even; increment mant when guard & (sticky | lsb).
REQ-023 ROUND: increment carry-out (mant 0xFF -> 0x100) SHALL give mant=0x80 and exp_pre+1.
REQ-024 Saturation after rounding: exp>15 -> o_result={sign,4'hF,8'hFF}, o_ovf=1.
REQ-025 Saturation after rounding: exp<1 -> o_result=0 (sign forced 0), o_unf=1.
REQ-026 Saturation after rounding: otherwise {sign, exp[3:0], mant} with o_ovf=o_unf=0.
REQ-027 Zero mantissa: o_result=0 with o_ovf=o_unf=0.
REQ-028 ROUND registers o_result, o_ovf, o_unf and moves to OUT.
REQ-029 Latency from acceptance edge to o_valid=1: 2+k cycles for k shifts; 1 cycle for zero mantissa.
REQ-030 OUT: o_valid=1, o_ready=0; o_result/o_ovf/o_unf held stable until i_ready=1; the transfer edge returns to IDLE.
REQ-031 No accept in the transfer cycle; the next accept is at the earliest one cycle after the transfer edge.
REQ-032 i_valid while o_ready=0 SHALL be ignored; no input is latched outside IDLE.

Reset
REQ-033 i_reset=1 at a clock edge SHALL force IDLE, o_valid=0, o_ready=1 after that edge, in any state.
REQ-034 Reset values: o_result=0, o_ovf=0, o_unf=0, internal registers 0.
REQ-035 Reset has priority over a simultaneous i_valid or i_ready.
REQ-036 An operand in flight during reset SHALL be discarded.

Verification
REQ-037 Normal: s=0, exp=7, man=0x4000 -> o_result=0x780, o_valid 3 cycles after accept.
REQ-038 Round carry: s=1, exp=7, man=0xFF80 -> o_result=0x1980, o_ovf=o_unf=0, latency 2.
REQ-039 Overflow: s=0, exp=20, man=0x8000 -> o_result=0xFFF, o_ovf=1.
REQ-040 Underflow: exp=-3, man=0x8000 -> o_result=0, o_unf=1; zero input man=0 -> o_result=0 with 1-cycle latency.
REQ-041 Backpressure: i_ready=0 for 5 cycles in OUT -> o_result held, o_ready=0, extra i_valid ignored; i_ready=1 -> single transfer, then IDLE.
REQ-042 Reset mid-operation: man=0x0001, i_reset asserted during NORM -> next cycle IDLE, o_valid=0, no output produced.
